spgd_adc_integrator: RTL and testbench
======================================

# spgd_adc_integrator

Responder end of the ADC_EN / ADC_DONE handshake driven by the SPGD sequencer. It discards a settling window, then integrates a fixed number of signed ADC samples into a metric sum J. It signals completion with a held ADC_DONE level. It also latches J+ and J- on the sequencer's J_P_WRT / J_M_WRT strobes and presents the registered difference used by the gradient/update math.

## Interface
- ADC_WIDTH, 14: ADC sample width, signed two's complement.
- SETTLE_CYCLES, 10: samples discarded after capture start (minimum 1).
- SAMPLE_COUNT, 1024: integrated samples; must be a power of two ≥ 2.
- ACC_WIDTH, ADC_WIDTH + log2(SAMPLE_COUNT) (24): signed accumulator width; overflow is impossible by construction.

Ports:
- ADC_CLK  in  1  sole clock; all logic is on its rising edge.
- REG_RST  in  1  synchronous, active-high reset.
- ADC_EN  in  1  capture request level from the sequencer.
- ADC_DATA  in  ADC_WIDTH  signed sample; valid every cycle.
- J_P_WRT  in  1  one-cycle strobe: J_P <= J_SUM.
- J_M_WRT  in  1  one-cycle strobe: J_M <= J_SUM.
- ADC_DONE  out  1  capture complete; held until ADC_EN is low.
- ABORT  out  1  one-cycle pulse when ADC_EN drops mid-capture.
- J_SUM  out  ACC_WIDTH  signed result of the last completed capture.
- J_P, J_M  out  ACC_WIDTH  signed latched metrics.
- DELTA_J  out  ACC_WIDTH+1  signed, registered J_P - J_M.
- ADC_PEAK  out  ADC_WIDTH  signed maximum sample of the last completed capture (see Configuration).

## Operation
- States: IDLE, SETTLE, ACCUM, DONE.
- IDLE: when ADC_EN=1, clear the accumulator and counter, then go to SETTLE. Otherwise stay in IDLE.
- SETTLE: count SETTLE_CYCLES cycles and ignore ADC_DATA. Go to ACCUM after the last one.
- ACCUM:
  - Each cycle, add sign-extended ADC_DATA to the accumulator.
  - After the SAMPLE_COUNT-th add, copy the accumulator to J_SUM and go to DONE.
- DONE: ADC_DONE=1 while ADC_EN=1. When ADC_EN=0, go to IDLE; ADC_DONE is 0 from that next cycle onward.
- ADC_EN=0 while in SETTLE or ACCUM:
  - Go to IDLE and pulse ABORT for one cycle.
  - J_SUM and ADC_PEAK are unchanged.
  - A partial sum is never published.
- A new capture requires ADC_EN to be seen low, then high. Holding ADC_EN high in DONE never retriggers.
- J_P_WRT / J_M_WRT are accepted in any state and always copy the current J_SUM, the last completed value.
- If both strobes arrive in the same cycle, both registers load the same J_SUM, so DELTA_J becomes 0.
- DELTA_J is recomputed every cycle from the registered J_P and J_M. It is full width (ACC_WIDTH+1 bits) and never wraps.
- On REG_RST:
  - All outputs and registers go to 0 and the state goes to IDLE.
  - REG_RST overrides ADC_EN in the same cycle.
  - Reset mid-capture discards everything, with no ABORT pulse.

## Timing
- ADC_EN first seen high at edge k: SETTLE covers edges k+1 .. k+SETTLE_CYCLES.
- Samples are taken at edges k+SETTLE_CYCLES+1 .. k+SETTLE_CYCLES+SAMPLE_COUNT.
- ADC_DONE and the new J_SUM are visible together, 1+SETTLE_CYCLES+SAMPLE_COUNT cycles after edge k (1035 with defaults).
- J_P / J_M update one cycle after their strobe. DELTA_J follows one cycle after that.
- ABORT is high in the cycle after the edge at which ADC_EN=0 is sampled.
- Reset values: ADC_DONE=0, ABORT=0, J_SUM=0, J_P=0, J_M=0, DELTA_J=0, ADC_PEAK=0.

## Configuration
- SPGD_ADC_PEAK_EN defined:
  - A running signed maximum of ADC_DATA is tracked during ACCUM.
  - It is initialised to the most negative value at capture start.
  - It is copied to ADC_PEAK together with J_SUM.
- SPGD_ADC_PEAK_EN undefined: no peak logic is built and ADC_PEAK is tied to 0. The port is always present.

## Structure
- Shared package spgd_pkg holds:
  - the state encoding constants (IDLE=2'd0, SETTLE=2'd1, ACCUM=2'd2, DONE=2'd3);
  - the clog2-based ACC_WIDTH helper function;
  - the defaults for SETTLE_CYCLES and SAMPLE_COUNT, shared with the sequencer's ADC timing constant.
- One sub-module, spgd_sample_acc, contains the clear/enable signed accumulator and the optional peak tracker.
- The control FSM and the J_P / J_M / DELTA_J registers stay in the top level.

## Test plan
- REG_RST high for 3 cycles while ADC_EN=1 -> all outputs 0; capture starts only after REG_RST falls.
- ADC_DATA=+100 constant, ADC_EN held -> ADC_DONE rises exactly 1035 cycles after the first ADC_EN-high edge; J_SUM=102400.
- ADC_DATA=-8192 constant -> J_SUM=-8388608 (24-bit minimum, no wrap); with the macro defined, ADC_PEAK=-8192.
- ADC_EN dropped after 500 samples -> ABORT pulses once; ADC_DONE stays 0; J_SUM keeps 102400. Re-raising ADC_EN restarts the full 1035-cycle capture.
- Capture +100, pulse J_P_WRT; capture +50, pulse J_M_WRT -> J_P=102400, J_M=51200, DELTA_J=51200. Then pulse both strobes together -> DELTA_J=0 two cycles later.
- ADC_EN held 20 cycles past DONE -> ADC_DONE high all 20 cycles, low from the cycle after ADC_EN=0; no second capture occurs.

Source files
------------

// File: rtl/spgd_pkg.sv
// Shared SPGD definitions: ADC integrator state encoding, accumulator width
// helper and default ADC timing shared with the sequencer.
package spgd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACCUM  = 2'd2,
        DONE   = 2'd3
    } adc_state_t;

    // Default ADC timing; the sequencer derives its capture timeout from these.
    localparam int unsigned SETTLE_CYCLES_DEF = 10;
    localparam int unsigned SAMPLE_COUNT_DEF  = 1024;

    // Width that holds SAMPLE_COUNT worst-case samples without overflow.
    function automatic int unsigned acc_width(input int unsigned adc_w,
                                              input int unsigned samples);
        return adc_w + $clog2(samples);
    endfunction

endpackage

// File: rtl/spgd_sample_acc.sv
// Clear/enable signed sample accumulator with an optional running peak.
// Peak tracking is built only when SPGD_ADC_PEAK_EN is defined; otherwise
// the peak output is a constant 0.
module spgd_sample_acc #(
    parameter int unsigned ADC_WIDTH = 14,
    parameter int unsigned ACC_WIDTH = 24
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        en,
    input  logic signed [ADC_WIDTH-1:0] data,
    output logic signed [ACC_WIDTH-1:0] sum,
    output logic signed [ADC_WIDTH-1:0] peak
);

    logic signed [ACC_WIDTH-1:0] data_ext;

    assign data_ext = {{(ACC_WIDTH-ADC_WIDTH){data[ADC_WIDTH-1]}}, data};

    // Running sum: cleared at capture start, one add per enabled cycle.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum + data_ext;
        end
    end

`ifdef SPGD_ADC_PEAK_EN
    // Running signed maximum, seeded with the most negative sample value.
    always_ff @(posedge clk) begin
        if (rst) begin
            peak <= '0;
        end else if (clr) begin
            peak <= {1'b1, {(ADC_WIDTH-1){1'b0}}};
        end else if (en && (data > peak)) begin
            peak <= data;
        end
    end
`else
    assign peak = '0;
`endif

endmodule

// File: rtl/spgd_adc_integrator.sv
// SPGD ADC integrator: responder side of the ADC_EN/ADC_DONE handshake.
// Discards a settling window, integrates SAMPLE_COUNT samples into J_SUM,
// latches J+/J- on sequencer strobes and registers their difference.
// Optional ADC_PEAK reporting is enabled by defining SPGD_ADC_PEAK_EN.
module spgd_adc_integrator
    import spgd_pkg::*;
#(
    parameter int unsigned ADC_WIDTH     = 14,
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int unsigned SAMPLE_COUNT  = SAMPLE_COUNT_DEF,
    parameter int unsigned ACC_WIDTH     = acc_width(ADC_WIDTH, SAMPLE_COUNT)
) (
    input  logic                        ADC_CLK,
    input  logic                        REG_RST,
    input  logic                        ADC_EN,
    input  logic signed [ADC_WIDTH-1:0] ADC_DATA,
    input  logic                        J_P_WRT,
    input  logic                        J_M_WRT,
    output logic                        ADC_DONE,
    output logic                        ABORT,
    output logic signed [ACC_WIDTH-1:0] J_SUM,
    output logic signed [ACC_WIDTH-1:0] J_P,
    output logic signed [ACC_WIDTH-1:0] J_M,
    output logic signed [ACC_WIDTH:0]   DELTA_J,
    output logic signed [ADC_WIDTH-1:0] ADC_PEAK
);

    // One counter serves both the settle window and the sample window.
    localparam int unsigned CNT_MAX = (SAMPLE_COUNT > SETTLE_CYCLES) ? SAMPLE_COUNT
                                                                    : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    adc_state_t                  state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        settle_last, accum_last;
    logic                        acc_clr, acc_en, last_add;
    logic                        done_d, abort_d;
    logic                        publish_q;
    logic signed [ACC_WIDTH-1:0] acc_sum;
    logic signed [ADC_WIDTH-1:0] acc_peak;

    assign settle_last = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
    assign accum_last  = (cnt_q == CNT_W'(SAMPLE_COUNT - 1));

    // State and window counter registers.
    always_ff @(posedge ADC_CLK) begin
        if (REG_RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state decode; ADC_EN low mid-capture always returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ADC_EN) state_d = SETTLE;
            SETTLE:  if (!ADC_EN) state_d = IDLE;
                     else if (settle_last) state_d = ACCUM;
            ACCUM:   if (!ADC_EN) state_d = IDLE;
                     else if (accum_last) state_d = DONE;
            DONE:    if (!ADC_EN) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath controls and next values of the registered handshake outputs.
    always_comb begin
        acc_clr  = (state_q == IDLE) && ADC_EN;
        acc_en   = (state_q == ACCUM) && ADC_EN;
        last_add = acc_en && accum_last;
        done_d   = (state_q == DONE) && ADC_EN;
        abort_d  = ((state_q == SETTLE) || (state_q == ACCUM)) && !ADC_EN;
        cnt_d    = cnt_q;
        if (acc_clr) begin
            cnt_d = '0;
        end else if ((state_q == SETTLE) && ADC_EN) begin
            cnt_d = settle_last ? '0 : cnt_q + 1'b1;
        end else if (acc_en) begin
            cnt_d = accum_last ? '0 : cnt_q + 1'b1;
        end
    end

    spgd_sample_acc #(
        .ADC_WIDTH (ADC_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_sample_acc (
        .clk  (ADC_CLK),
        .rst  (REG_RST),
        .clr  (acc_clr),
        .en   (acc_en),
        .data (ADC_DATA),
        .sum  (acc_sum),
        .peak (acc_peak)
    );

    // Handshake outputs; the sum is published the cycle after its final add.
    always_ff @(posedge ADC_CLK) begin
        if (REG_RST) begin
            ADC_DONE  <= 1'b0;
            ABORT     <= 1'b0;
            publish_q <= 1'b0;
            J_SUM     <= '0;
        end else begin
            ADC_DONE  <= done_d;
            ABORT     <= abort_d;
            publish_q <= last_add;
            if (publish_q) J_SUM <= acc_sum;
        end
    end

    // Metric latches and their full-width registered difference.
    always_ff @(posedge ADC_CLK) begin
        if (REG_RST) begin
            J_P     <= '0;
            J_M     <= '0;
            DELTA_J <= '0;
        end else begin
            if (J_P_WRT) J_P <= J_SUM;
            if (J_M_WRT) J_M <= J_SUM;
            DELTA_J <= {J_P[ACC_WIDTH-1], J_P} - {J_M[ACC_WIDTH-1], J_M};
        end
    end

`ifdef SPGD_ADC_PEAK_EN
    // Peak of the last completed capture, published alongside J_SUM.
    always_ff @(posedge ADC_CLK) begin
        if (REG_RST) begin
            ADC_PEAK <= '0;
        end else if (publish_q) begin
            ADC_PEAK <= acc_peak;
        end
    end
`else
    assign ADC_PEAK = acc_peak;
`endif

endmodule

// File: tb/tb_spgd_adc_integrator.sv
// Scoreboard bench for spgd_adc_integrator with default parameters.
// Works with or without SPGD_ADC_PEAK_EN defined.
module tb_spgd_adc_integrator;

    localparam int CAP_LAT = 1 + 10 + 1024;

`ifdef SPGD_ADC_PEAK_EN
    localparam longint PK100 = 100;
    localparam longint PK50  = 50;
    localparam longint PKNEG = -8192;
`else
    localparam longint PK100 = 0;
    localparam longint PK50  = 0;
    localparam longint PKNEG = 0;
`endif

    typedef struct {
        bit     is_abort;
        int     cyc;
        longint sum;
        longint peak;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en  = 1'b1;
    logic signed [13:0] data = 14'sd100;
    logic               jp = 1'b0;
    logic               jm = 1'b0;
    logic               done, abort;
    logic signed [23:0] j_sum, j_p, j_m;
    logic signed [24:0] delta;
    logic signed [13:0] peak;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic done_prev = 1'b0;
    exp_t exp_q[$];

    spgd_adc_integrator dut (
        .ADC_CLK  (clk),
        .REG_RST  (rst),
        .ADC_EN   (en),
        .ADC_DATA (data),
        .J_P_WRT  (jp),
        .J_M_WRT  (jm),
        .ADC_DONE (done),
        .ABORT    (abort),
        .J_SUM    (j_sum),
        .J_P      (j_p),
        .J_M      (j_m),
        .DELTA_J  (delta),
        .ADC_PEAK (peak)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DONE rising edge or ABORT pulse consumes one expectation.
    task automatic score(input bit is_abort);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got %s at cycle %0d, expected none",
                     is_abort ? "ABORT" : "DONE", cyc);
        end else begin
            e = exp_q.pop_front();
            chk("event_is_abort", is_abort, e.is_abort);
            chk("event_cycle", cyc, e.cyc);
            chk("event_j_sum", j_sum, e.sum);
            chk("event_peak", peak, e.peak);
        end
    endtask

    always @(negedge clk) begin
        if (done && !done_prev) score(1'b0);
        if (abort) score(1'b1);
        done_prev = done;
    end

    task automatic push(input bit is_abort, input int c, input longint s, input longint p);
        exp_t e;
        e.is_abort = is_abort;
        e.cyc      = c;
        e.sum      = s;
        e.peak     = p;
        exp_q.push_back(e);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < CAP_LAT + 50 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("done_within_budget", seen, 1);
    endtask

    task automatic drop_en(input longint exp_sum);
        @(posedge clk); #1 en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("done_low_after_en_low", done, 0);
        chk("j_sum_held", j_sum, exp_sum);
    endtask

    task automatic capture(input logic signed [13:0] d, input longint s, input longint p);
        @(posedge clk); #1;
        data = d;
        en   = 1'b1;
        push(1'b0, cyc + CAP_LAT + 1, s, p);
        wait_done();
        drop_en(s);
    endtask

    initial begin
        // Reset held with ADC_EN high.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_done", done, 0);
        chk("rst_abort", abort, 0);
        chk("rst_j_sum", j_sum, 0);
        chk("rst_j_p", j_p, 0);
        chk("rst_j_m", j_m, 0);
        chk("rst_delta", delta, 0);
        chk("rst_peak", peak, 0);
        @(posedge clk); #1 rst = 1'b0;
        push(1'b0, cyc + CAP_LAT + 1, 102400, PK100);
        wait_done();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("done_held", done, 1);
        end
        drop_en(102400);

        // Abort partway through the sample window.
        begin
            int c;
            @(posedge clk); #1;
            data = 14'sd7;
            en   = 1'b1;
            c    = cyc;
            push(1'b1, c + 512, 102400, PK100);
            repeat (511) @(posedge clk);
            #1 en = 1'b0;
            repeat (4) @(negedge clk);
            chk("abort_no_done", done, 0);
            chk("abort_j_sum", j_sum, 102400);
        end

        // Full restart, then J+ strobe.
        capture(14'sd100, 102400, PK100);
        @(posedge clk); #1 jp = 1'b1;
        @(posedge clk); #1 jp = 1'b0;
        @(negedge clk);
        chk("j_p_latch", j_p, 102400);
        @(negedge clk);
        chk("delta_after_jp", delta, 102400);

        capture(14'sd50, 51200, PK50);
        @(posedge clk); #1 jm = 1'b1;
        @(posedge clk); #1 jm = 1'b0;
        @(negedge clk);
        chk("j_m_latch", j_m, 51200);
        chk("j_p_kept", j_p, 102400);
        @(negedge clk);
        chk("delta_p_minus_m", delta, 51200);

        // Both strobes together.
        @(posedge clk); #1 begin jp = 1'b1; jm = 1'b1; end
        @(posedge clk); #1 begin jp = 1'b0; jm = 1'b0; end
        @(negedge clk);
        chk("both_j_p", j_p, 51200);
        chk("both_j_m", j_m, 51200);
        @(negedge clk);
        chk("delta_zero", delta, 0);

        // Most negative samples fill the accumulator exactly to its minimum.
        capture(-14'sd8192, -8388608, PKNEG);
        chk("delta_still_zero", delta, 0);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
